// File: rtl/ysyx_23060096_core_seq_if.sv
// Fetch and load/store bus handshakes between the core sequencer (master)
// and the IFU/LSU bus ports (slave).
interface ysyx_23060096_core_seq_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_rsp_valid;
  logic ifu_rsp_err;
  logic lsu_req_valid;
  logic lsu_req_wen;
  logic lsu_req_ready;
  logic lsu_rsp_valid;
  logic lsu_rsp_err;

  modport master (
    output ifu_req_valid,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_err,
    output lsu_req_valid,
    output lsu_req_wen,
    input  lsu_req_ready,
    input  lsu_rsp_valid,
    input  lsu_rsp_err
  );

  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_err,
    input  lsu_req_valid,
    input  lsu_req_wen,
    output lsu_req_ready,
    output lsu_rsp_valid,
    output lsu_rsp_err
  );
endinterface

// File: rtl/ysyx_23060096_core_seq.sv
// Multi-cycle sequencer for the NPC core: fetch, decode settle, load/store, writeback.
// Define YSYX_23060096_PERF_EN to build the mcycle/minstret performance counters.
module ysyx_23060096_core_seq #(
  parameter int unsigned CNT_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060096_core_seq_if.master bus,
  output logic                   inst_we,
  input  logic                   dec_regwr,
  input  logic                   dec_memwr,
  input  logic                   dec_memtoreg,
  input  logic                   dec_illegal,
  input  logic                   dec_ebreak,
  output logic                   ld_we,
  output logic                   reg_we,
  output logic                   pc_we,
  output logic                   halted,
  output logic [1:0]             halt_code,
  output logic [CNT_W-1:0]       mcycle,
  output logic [CNT_W-1:0]       minstret
);

  typedef enum logic [2:0] {
    StRst, StFetch, StFwait, StDecode, StMem, StMwait, StWb, StHalt
  } state_t;

  state_t state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRst;
      halt_code <= 2'b00;
    end else begin
      unique case (state_q)
        StRst:   state_q <= StFetch;
        StFetch: if (bus.ifu_req_ready) state_q <= StFwait;
        StFwait: begin
          if (bus.ifu_rsp_valid) begin
            if (bus.ifu_rsp_err) begin
              state_q   <= StHalt;
              halt_code <= 2'b11;
            end else begin
              state_q <= StDecode;
            end
          end
        end
        StDecode: begin
          if (dec_illegal) begin
            state_q   <= StHalt;
            halt_code <= 2'b10;
          end else if (dec_ebreak) begin
            state_q   <= StHalt;
            halt_code <= 2'b01;
          end else if (dec_memwr || dec_memtoreg) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem:   if (bus.lsu_req_ready) state_q <= StMwait;
        StMwait: begin
          if (bus.lsu_rsp_valid) begin
            if (bus.lsu_rsp_err) begin
              state_q   <= StHalt;
              halt_code <= 2'b11;
            end else begin
              state_q <= StWb;
            end
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StRst;
      endcase
    end
  end

  // Strobes are decoded from the state so a halting instruction never reaches WB.
  always_comb begin
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    inst_we           = 1'b0;
    ld_we             = 1'b0;
    reg_we            = 1'b0;
    pc_we             = 1'b0;
    unique case (state_q)
      StFetch: bus.ifu_req_valid = 1'b1;
      StFwait: inst_we = bus.ifu_rsp_valid & ~bus.ifu_rsp_err;
      StMem: begin
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_wen   = dec_memwr;
      end
      StMwait: ld_we = bus.lsu_rsp_valid & ~bus.lsu_rsp_err & dec_memtoreg;
      StWb: begin
        reg_we = dec_regwr;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state_q == StHalt);

`ifdef YSYX_23060096_PERF_EN
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (state_q != StRst && state_q != StHalt) mcycle_q <= mcycle_q + CNT_W'(1);
      if (state_q == StWb) minstret_q <= minstret_q + CNT_W'(1);
    end
  end

  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
`else
  assign mcycle   = '0;
  assign minstret = '0;
`endif

endmodule

// File: doc/ysyx_23060096_core_seq.md
# ysyx_23060096_core_seq

Multi-cycle sequencer for the NPC core datapath. It drives instruction fetch, passes the decoded control word (RegWr, MemWr, MemtoReg) to the datapath at the right cycle, runs load/store handshakes, and qualifies register-file and PC writes. It sits between the IFU/LSU bus ports and the decode/execute datapath, turning the combinational decoder into a sequenced multi-cycle core.

## Interface
Parameters:
- `CNT_W`, default 64: width of the performance counters.

Ports:
- `clk`  in  1  core clock; every register samples on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ifu_req_valid`  out  1  fetch request at the current PC.
- `ifu_req_ready`  in  1  fetch request accepted.
- `ifu_rsp_valid`  in  1  instruction word valid.
- `ifu_rsp_err`  in  1  fetch bus error; qualified by `ifu_rsp_valid`.
- `inst_we`  out  1  latch the instruction register.
- `dec_regwr`  in  1  decoded RegWr.
- `dec_memwr`  in  1  decoded MemWr.
- `dec_memtoreg`  in  1  decoded MemtoReg (load).
- `dec_illegal`  in  1  no decoder pattern matched.
- `dec_ebreak`  in  1  ebreak decoded.
- `lsu_req_valid`  out  1  data request.
- `lsu_req_wen`  out  1  1 = store, 0 = load.
- `lsu_req_ready`  in  1  data request accepted.
- `lsu_rsp_valid`  in  1  load data or store acknowledge.
- `lsu_rsp_err`  in  1  data bus error; qualified by `lsu_rsp_valid`.
- `ld_we`  out  1  latch load data.
- `reg_we`  out  1  register-file write enable.
- `pc_we`  out  1  PC update (next PC comes from the branch logic).
- `halted`  out  1  core stopped.
- `halt_code`  out  2  00 running, 01 ebreak, 10 illegal, 11 bus error.
- `mcycle`  out  CNT_W  cycle count since reset.
- `minstret`  out  CNT_W  retired-instruction count since reset.

## Operation
- The state register is the only control storage. All outputs are decoded combinationally from the state register, plus the `dec_*` inputs where listed below.
- State transitions:
  - RST → FETCH unconditionally (one cycle after reset release).
  - FETCH: `ifu_req_valid`=1. Go to FWAIT on `ifu_req_ready`.
  - FWAIT: on `ifu_rsp_valid`, go to HALT(11) if `ifu_rsp_err`. Otherwise assert `inst_we` and go to DECODE.
  - DECODE: one settle cycle with no outputs asserted.
    - Priority order: `dec_illegal` → HALT(10); then `dec_ebreak` → HALT(01); then (`dec_memwr`|`dec_memtoreg`) → MEM; otherwise → WB.
  - MEM: `lsu_req_valid`=1 and `lsu_req_wen`=`dec_memwr`. Go to MWAIT on `lsu_req_ready`.
  - MWAIT: on `lsu_rsp_valid`, go to HALT(11) if `lsu_rsp_err`. Otherwise assert `ld_we` only when `dec_memtoreg`=1, and go to WB.
  - WB: `reg_we`=`dec_regwr`, `pc_we`=1, `minstret`+1, then go to FETCH.
  - HALT: absorbing. Leaves only through `rst`.
- A halting instruction never asserts `reg_we` or `pc_we`, so the PC still points at the faulting instruction.
- `halt_code` is registered. It is written on entry to HALT and is 00 otherwise.
- Bus contract: a response is never returned in the same cycle its request is accepted. `*_rsp_valid` is ignored outside the FWAIT and MWAIT states.
- The `dec_*` inputs are required to stay stable from DECODE through WB, which holds because the instruction register is written only in FWAIT.
- Counters wrap modulo 2^CNT_W. `mcycle` increments every cycle that is not in RST or HALT.

## Timing
- Reset values:
  - State = RST.
  - `halt_code`=0, `halted`=0, `mcycle`=0, `minstret`=0.
  - All request, strobe and write-enable outputs = 0.
- Latency with zero wait states, measured from FETCH entry to the next FETCH entry:
  - ALU, branch or jump instruction: 4 cycles (FETCH, FWAIT, DECODE, WB).
  - Load or store: 6 cycles.
- Each wait cycle on ready or rsp_valid adds exactly one cycle.
- Request valid lines stay high until ready is seen; they never drop early.
- `rst` asserted mid-transaction: state goes to RST immediately, the outstanding request or response is abandoned, and the counters clear.

## Configuration
- `YSYX_23060096_PERF_EN` defined: `mcycle` and `minstret` are implemented as described above.
- Macro undefined: the counter registers are not built, and both outputs are tied to 0.

## Test plan
- Reset, then an `addi` with zero-wait buses → `inst_we` in cycle 2, `reg_we`=`pc_we`=1 in cycle 4, next `ifu_req_valid` in cycle 5; `minstret`=1.
- A load with `lsu_req_ready` delayed 2 cycles and `lsu_rsp_valid` delayed 3 cycles → `lsu_req_valid` held for 3 cycles with `lsu_req_wen`=0, `ld_we` pulses once, retirement happens 11 cycles after FETCH entry.
- A store (`dec_memwr`=1, `dec_regwr`=0) → `lsu_req_wen`=1, no `ld_we`, and `reg_we`=0 in WB.
- `dec_illegal` together with `dec_ebreak` → `halted`=1 and `halt_code`=10 with no `pc_we`. Run 100 idle cycles and check `mcycle` is frozen.
- `lsu_rsp_err` in MWAIT → `halt_code`=11. Then a `rst` pulse in the middle of a following FWAIT → outputs return to reset values and fetch restarts.
- With the macro undefined → `mcycle`=`minstret`=0 throughout the first scenario.
